// File: rtl/row_pkg.sv
// rtl/row_pkg.sv - shared row constants and FSM state type for row_encoder / row_decoder
package row_pkg;

  localparam int ROW_ROWS  = 16;
  localparam int ROW_IDX_W = $clog2(ROW_ROWS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } row_state_e;

endpackage

// File: rtl/row_prio_enc.sv
// rtl/row_prio_enc.sv - masked priority encoder: first set bit of vec_i at or above start_i, wrapping
module row_prio_enc
  import row_pkg::*;
#(
  parameter int ROWS = ROW_ROWS
) (
  input  logic [ROWS-1:0]         vec_i,
  input  logic [$clog2(ROWS)-1:0] start_i,
  output logic [$clog2(ROWS)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IDX_W = $clog2(ROWS);

  int pos;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int i = 0; i < ROWS; i++) begin
      pos = (int'(start_i) + i) % ROWS;
      if (!any_o && vec_i[pos]) begin
        idx_o = IDX_W'(pos);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_encoder.sv
// rtl/row_encoder.sv - issues the set rows of a request vector as binary indices, one per beat.
// ROW_ENCODER_RR_EN selects round-robin instead of lowest-index-first selection.
module row_encoder
  import row_pkg::*;
#(
  parameter int ROWS = ROW_ROWS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROWS-1:0]         in_req,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [$clog2(ROWS)-1:0] out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    done,
  output logic [$clog2(ROWS):0]   pend_cnt
);

  localparam int IDX_W = $clog2(ROWS);

  row_state_e       state_q, state_d;
  logic [ROWS-1:0]  pend_q, pend_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [IDX_W:0]   cnt;

`ifdef ROW_ENCODER_RR_EN
  // Points one past the last issued row; kept across vectors.
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  row_prio_enc #(.ROWS(ROWS)) u_sel (
    .vec_i   (pend_q),
    .start_i (start),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < ROWS; i++) begin
      cnt = cnt + (IDX_W+1)'(pend_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
`ifdef ROW_ENCODER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
`ifdef ROW_ENCODER_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
`ifdef ROW_ENCODER_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (|in_req) begin
            pend_d  = in_req;
            state_d = BUSY;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready && sel_any) begin
          pend_d[sel_idx] = 1'b0;
`ifdef ROW_ENCODER_RR_EN
          ptr_d = (sel_idx == IDX_W'(ROWS-1)) ? '0 : sel_idx + 1'b1;
`endif
          if (cnt == (IDX_W+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == BUSY);
    out_idx   = sel_idx;
    out_last  = (state_q == BUSY) && (cnt == (IDX_W+1)'(1));
    done      = done_q;
    pend_cnt  = cnt;
  end

endmodule
